// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and write enables, decodes ALU control, traps illegal instrs.
module multicycle_ctrl #(
    parameter bit TRAP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem2reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     cur;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       instr_illegal;

    assign state = cur;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: instr_illegal = 1'b0;
            OP_R:                                instr_illegal = !funct_ok;
            default:                             instr_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:   if (mem_ready) cur <= DECODE;
                DECODE: begin
                    if (instr_illegal) begin
                        cur <= TRAP_EN ? TRAP : FETCH;
                    end else begin
                        case (opcode)
                            OP_LW, OP_SW: cur <= MEMADR;
                            OP_R:         cur <= EXEC;
                            OP_BEQ:       cur <= BRANCH;
                            OP_ADDI:      cur <= ADDIEX;
                            OP_J:         cur <= JUMP;
                            default:      cur <= FETCH;
                        endcase
                    end
                end
                MEMADR:  cur <= (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (mem_ready) cur <= MEMWB;
                MEMWR:   if (mem_ready) cur <= FETCH;
                EXEC:    cur <= ALUWB;
                ADDIEX:  cur <= ADDIWB;
                TRAP:    cur <= TRAP;
                default: cur <= FETCH;
            endcase
        end
    end

    // Moore decode of state; FETCH and BRANCH enables also follow mem_ready/zero, and
    // reset masks every write enable so an aborted instruction never writes.
    always_comb begin
        pc_en       = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem2reg     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b010;
        pc_src      = 2'b00;
        illegal     = 1'b0;
        case (cur)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                illegal   = instr_illegal && !TRAP_EN;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD:  iord = 1'b1;
            MEMWB: begin
                mem2reg   = 1'b1;
                reg_write = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pc_en       = zero;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: reg_write = 1'b1;
            JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
        if (rst) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model pushes per-cycle expected
// outputs; a negedge monitor pops and compares against the selected DUT (TRAP_EN 0 or 1).
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem2reg, src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] pc_src;
        logic       ill;
    } vec_t;

    typedef struct packed {
        logic which;
        vec_t v;
    } q_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic [1:0] pc_en_w, iord_w, ir_write_w, mem_write_w, reg_write_w, reg_dst_w;
    logic [1:0] mem2reg_w, src_a_w, illegal_w;
    logic [1:0] src_b_w [2];
    logic [2:0] alu_w [2];
    logic [1:0] pc_src_w [2];
    logic [3:0] state_w [2];
    vec_t       act [2];

    multicycle_ctrl #(.TRAP_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en_w[0]), .iord(iord_w[0]), .ir_write(ir_write_w[0]),
        .mem_write(mem_write_w[0]), .reg_write(reg_write_w[0]), .reg_dst(reg_dst_w[0]),
        .mem2reg(mem2reg_w[0]), .alu_src_a(src_a_w[0]), .alu_src_b(src_b_w[0]),
        .alu_control(alu_w[0]), .pc_src(pc_src_w[0]), .illegal(illegal_w[0]), .state(state_w[0])
    );

    multicycle_ctrl #(.TRAP_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en_w[1]), .iord(iord_w[1]), .ir_write(ir_write_w[1]),
        .mem_write(mem_write_w[1]), .reg_write(reg_write_w[1]), .reg_dst(reg_dst_w[1]),
        .mem2reg(mem2reg_w[1]), .alu_src_a(src_a_w[1]), .alu_src_b(src_b_w[1]),
        .alu_control(alu_w[1]), .pc_src(pc_src_w[1]), .illegal(illegal_w[1]), .state(state_w[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_act
        assign act[g] = {state_w[g], pc_en_w[g], iord_w[g], ir_write_w[g], mem_write_w[g],
                         reg_write_w[g], reg_dst_w[g], mem2reg_w[g], src_a_w[g], src_b_w[g],
                         alu_w[g], pc_src_w[g], illegal_w[g]};
    end

    always #5 clk = ~clk;

    q_t   sb[$];
    int   checks = 0;
    int   errors = 0;
    logic sel = 1'b0;
    int   k, abort_at, forced;
    bit   aborted, ill;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            q_t   e;
            vec_t a;
            e = sb.pop_front();
            a = act[e.which];
            checks++;
            if (a !== e.v) begin
                errors++;
                $display("FAIL dut%0d_state%0d actual=%h expected=%h", e.which, e.v.st, a, e.v);
            end
        end
    end

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic vec_t model(input int st, input bit mr, input bit r);
        vec_t v = '0;
        v.st  = 4'(st);
        v.alu = 3'b010;
        case (st)
            0:  begin v.src_b = 2'b01; v.ir_write = mr; v.pc_en = mr; end
            1:  begin v.src_b = 2'b11; v.ill = ill && !sel; end
            2:  begin v.src_a = 1'b1; v.src_b = 2'b10; end
            3:  v.iord = 1'b1;
            4:  begin v.mem2reg = 1'b1; v.reg_write = 1'b1; end
            5:  begin v.iord = 1'b1; v.mem_write = 1'b1; end
            6:  begin v.src_a = 1'b1; v.alu = alu_of(funct); end
            7:  begin v.reg_dst = 1'b1; v.reg_write = 1'b1; end
            8:  begin v.src_a = 1'b1; v.alu = 3'b110; v.pc_src = 2'b01; v.pc_en = zero; end
            9:  begin v.src_a = 1'b1; v.src_b = 2'b10; end
            10: v.reg_write = 1'b1;
            11: begin v.pc_src = 2'b10; v.pc_en = 1'b1; end
            12: v.ill = 1'b1;
            default: ;
        endcase
        if (r) begin
            v.pc_en = 1'b0; v.ir_write = 1'b0; v.mem_write = 1'b0; v.reg_write = 1'b0; v.ill = 1'b0;
        end
        return v;
    endfunction

    task automatic rst_cycle(input int st);
        rst = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        sb.push_back({sel, model(st, mem_ready, 1'b1)});
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step(input int st, input bit mr);
        if (aborted) return;
        if (k == abort_at) begin
            rst_cycle(st);
            aborted = 1'b1;
            return;
        end
        mem_ready = mr;
        sb.push_back({sel, model(st, mr, 1'b0)});
        k++;
        @(posedge clk); #1;
    endtask

    task automatic wait_state(input int st);
        int n = 0;
        bit m;
        while (!aborted) begin
            m = (forced >= 0) ? (n >= forced) : ($urandom_range(0, 2) != 0);
            step(st, m);
            n++;
            if (m) break;
        end
    endtask

    task automatic do_instr(input logic [5:0] op, input logic [5:0] f, input bit z,
                            input int ab, input int fw);
        opcode = op; funct = f; zero = z;
        k = 0; aborted = 1'b0; abort_at = ab; forced = fw;
        ill = !((op inside {LW, SW, BEQ, ADDI, JMP}) ||
                (op == RT && (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})));
        wait_state(0);
        step(1, 1'($urandom_range(0, 1)));
        if (ill) begin
            if (sel) repeat (10) step(12, 1'($urandom_range(0, 1)));
        end else begin
            case (op)
                LW:   begin step(2, 1'b1); wait_state(3); step(4, 1'b1); end
                SW:   begin step(2, 1'b1); wait_state(5); end
                RT:   begin step(6, 1'b1); step(7, 1'b1); end
                BEQ:  step(8, 1'b1);
                ADDI: begin step(9, 1'b1); step(10, 1'b1); end
                default: step(11, 1'b1);
            endcase
        end
    endtask

    logic [5:0] legal_f [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] bad_f   [4] = '{6'b000111, 6'b000000, 6'b100001, 6'b111111};
    logic [5:0] bad_op  [5] = '{6'b111111, 6'b000001, 6'b001101, 6'b100000, 6'b010000};
    logic [5:0] ops     [6] = '{LW, SW, RT, BEQ, ADDI, JMP};

    initial begin
        logic [5:0] op, f;
        int r;
        @(posedge clk); #1;
        rst_cycle(0);

        do_instr(RT, 6'b100000, 1'b0, -1, 0);
        do_instr(LW, 6'b000000, 1'b0, -1, 3);
        do_instr(BEQ, 6'b000000, 1'b1, -1, 0);
        do_instr(BEQ, 6'b000000, 1'b0, -1, 0);
        do_instr(RT, 6'b000111, 1'b0, -1, 0);
        do_instr(SW, 6'b000000, 1'b0, 7, 3);
        do_instr(JMP, 6'b000000, 1'b0, -1, 0);

        for (int i = 0; i < 200; i++) begin
            r  = int'($urandom_range(0, 7));
            op = (r < 6) ? ops[r] : bad_op[$urandom_range(0, 4)];
            f  = ($urandom_range(0, 5) == 0) ? bad_f[$urandom_range(0, 3)]
                                              : legal_f[$urandom_range(0, 4)];
            do_instr(op, f, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1, -1);
        end

        // Switch to the trapping instance; its state is unknown until reset lands.
        sel = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst_cycle(0);
        do_instr(RT, 6'b101010, 1'b0, -1, 0);
        do_instr(6'b111111, 6'b000000, 1'b0, -1, 0);
        rst_cycle(12);
        do_instr(ADDI, 6'b000000, 1'b0, -1, 1);
        do_instr(RT, 6'b000111, 1'b0, -1, 0);
        rst_cycle(12);
        do_instr(LW, 6'b000000, 1'b0, -1, -1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
